// File: rtl/float_addsub_pipe_if.sv
// Operand/result stream bundle for the pipelined binary32 adder/subtractor.
interface float_addsub_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [31:0] v1;
  logic [31:0] v2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] vres;

  modport master (
    output in_valid, op, v1, v2, out_ready,
    input  in_ready, out_valid, vres
  );

  modport slave (
    input  in_valid, op, v1, v2, out_ready,
    output in_ready, out_valid, vres
  );
endinterface

// File: rtl/float_addsub_pipe.sv
// Four-stage IEEE-754 binary32 add/subtract (unpack, align, add, normalize/round)
// with a single global stall; every stage advances together.
module float_addsub_pipe #(
  parameter bit FTZ = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  float_addsub_pipe_if.slave bus
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic adv;
  assign adv          = !(bus.out_valid && !bus.out_ready);
  assign bus.in_ready = adv;

  // S1 unpack / classify / swap
  logic        sa, sb, swap, nan_a, nan_b, inf_a, inf_b;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;
  logic        spec_c;
  logic [31:0] sval_c;

  always_comb begin
    sa    = bus.v1[31];
    sb    = bus.v2[31] ^ bus.op;
    nan_a = (bus.v1[30:23] == 8'hFF) && (bus.v1[22:0] != '0);
    nan_b = (bus.v2[30:23] == 8'hFF) && (bus.v2[22:0] != '0);
    inf_a = (bus.v1[30:23] == 8'hFF) && (bus.v1[22:0] == '0);
    inf_b = (bus.v2[30:23] == 8'hFF) && (bus.v2[22:0] == '0);
    // Zero/subnormal inputs use exponent 1 so subnormals align without a special path
    if (bus.v1[30:23] == '0) begin
      ea = 8'd1;
      ma = FTZ ? '0 : {1'b0, bus.v1[22:0]};
    end else begin
      ea = bus.v1[30:23];
      ma = {1'b1, bus.v1[22:0]};
    end
    if (bus.v2[30:23] == '0) begin
      eb = 8'd1;
      mb = FTZ ? '0 : {1'b0, bus.v2[22:0]};
    end else begin
      eb = bus.v2[30:23];
      mb = {1'b1, bus.v2[22:0]};
    end
    swap   = {eb, mb} > {ea, ma};
    spec_c = 1'b1;
    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) sval_c = QNAN;
    else if (inf_a)                                        sval_c = {sa, 8'hFF, 23'd0};
    else if (inf_b)                                        sval_c = {sb, 8'hFF, 23'd0};
    else begin
      spec_c = 1'b0;
      sval_c = '0;
    end
  end

  logic        s1_v, s1_sign, s1_sub, s1_spec;
  logic [7:0]  s1_exp, s1_diff;
  logic [23:0] s1_ml, s1_ms;
  logic [31:0] s1_sval;

  // S2 align with sticky collection
  logic [53:0] ext;
  logic [26:0] as_c;

  always_comb begin
    ext = {s1_ms, 3'b000, 27'd0} >> s1_diff;
    if (s1_diff >= 8'd27) as_c = {26'd0, |s1_ms};
    else                  as_c = {ext[53:28], ext[27] | (|ext[26:0])};
  end

  logic        s2_v, s2_sign, s2_sub, s2_spec;
  logic [7:0]  s2_exp;
  logic [26:0] s2_al, s2_as;
  logic [31:0] s2_sval;

  logic        s3_v, s3_sign, s3_sub, s3_spec;
  logic [7:0]  s3_exp;
  logic [27:0] s3_sum;
  logic [31:0] s3_sval;

  // S4 normalize / round / pack
  logic [4:0]  lzc;
  logic [26:0] m27;
  logic [8:0]  e9;
  logic        rnd;
  logic [31:0] pk, res_c;

  always_comb begin
    lzc = 5'd27;
    for (int unsigned i = 0; i < 27; i++)
      if (s3_sum[i]) lzc = 5'(26 - i);
    if (s3_sum[27]) begin
      m27 = {s3_sum[27:2], s3_sum[1] | s3_sum[0]};
      e9  = {1'b0, s3_exp} + 9'd1;
    end else if ({3'd0, lzc} < s3_exp) begin
      m27 = s3_sum[26:0] << lzc;
      e9  = {1'b0, s3_exp} - {4'd0, lzc};
    end else begin
      // Underflow: shift only down to exponent 1 and encode as subnormal (exp field 0)
      m27 = s3_sum[26:0] << (s3_exp - 8'd1);
      e9  = '0;
    end
    rnd = m27[2] & (m27[1] | m27[0] | m27[3]);
    pk  = {e9, m27[25:3]} + {31'd0, rnd};
    if (s3_spec)                   res_c = s3_sval;
    else if (s3_sum == '0)         res_c = {s3_sub ? 1'b0 : s3_sign, 31'd0};
    else if (FTZ && !m27[26])      res_c = {s3_sign, 31'd0};
    else if (pk[31:23] >= 9'd255)  res_c = {s3_sign, 8'hFF, 23'd0};
    else                           res_c = {s3_sign, pk[30:0]};
  end

  logic        s4_v;
  logic [31:0] vres_r;
  assign bus.out_valid = s4_v;
  assign bus.vres      = vres_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
      s3_v   <= 1'b0;
      s4_v   <= 1'b0;
      vres_r <= '0;
    end else if (adv) begin
      s1_v    <= bus.in_valid;
      s1_sign <= swap ? sb : sa;
      s1_sub  <= sa ^ sb;
      s1_exp  <= swap ? eb : ea;
      s1_diff <= swap ? (eb - ea) : (ea - eb);
      s1_ml   <= swap ? mb : ma;
      s1_ms   <= swap ? ma : mb;
      s1_spec <= spec_c;
      s1_sval <= sval_c;

      s2_v    <= s1_v;
      s2_sign <= s1_sign;
      s2_sub  <= s1_sub;
      s2_exp  <= s1_exp;
      s2_al   <= {s1_ml, 3'b000};
      s2_as   <= as_c;
      s2_spec <= s1_spec;
      s2_sval <= s1_sval;

      s3_v    <= s2_v;
      s3_sign <= s2_sign;
      s3_sub  <= s2_sub;
      s3_exp  <= s2_exp;
      s3_sum  <= s2_sub ? ({1'b0, s2_al} - {1'b0, s2_as}) : ({1'b0, s2_al} + {1'b0, s2_as});
      s3_spec <= s2_spec;
      s3_sval <= s2_sval;

      s4_v <= s3_v;
      if (s3_v) vres_r <= res_c;
    end
  end

endmodule

// File: tb/tb_float_addsub_pipe.sv
// Scoreboard bench for float_addsub_pipe: expected results queued on acceptance,
// compared against captured outputs in order, with latency and flow-control checks.
module tb_float_addsub_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  float_addsub_pipe_if bus ();
  float_addsub_pipe #(.FTZ(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed { logic [31:0] a; logic [31:0] b; logic o; logic [31:0] r; } vec_t;
  typedef struct { logic [31:0] r; int unsigned t; int unsigned id; } exp_t;

  localparam int unsigned NV = 24;
  vec_t vt [NV];
  exp_t exp_q [$];
  logic [31:0] act_res [0:255];
  int unsigned act_t [0:255];
  int unsigned n_out = 0;
  int unsigned cyc = 0;
  int unsigned rd = 0;
  int errors = 0;
  int checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rst_n && bus.out_valid && bus.out_ready && n_out < 256) begin
      act_res[n_out[7:0]] <= bus.vres;
      act_t[n_out[7:0]]   <= cyc;
      n_out               <= n_out + 1;
    end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic send(input int unsigned k, output int unsigned waited);
    waited = 0;
    bus.in_valid = 1'b1;
    bus.v1 = vt[k].a;
    bus.v2 = vt[k].b;
    bus.op = vt[k].o;
    @(negedge clk);
    while (!bus.in_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (bus.in_ready) exp_q.push_back('{vt[k].r, cyc, k});
    else begin
      errors++;
      $display("FAIL send_timeout vec=%0d in_ready=%b required=1", k, bus.in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int unsigned budget = 200;
    while (int'(n_out - rd) < exp_q.size() && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL drain_timeout outputs=%0d required=%0d", n_out - rd, exp_q.size());
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.op = 1'b0; bus.v1 = '0; bus.v2 = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b required=0", bus.out_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got=%b required=0", bus.out_valid); end
    checks++;
    if (bus.vres !== 32'h0) begin errors++; $display("FAIL post_reset_vres got=%h required=00000000", bus.vres); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b required=1", bus.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    int unsigned w;
    exp_t e;
    for (int unsigned k = 0; k < NV; k++) begin
      send(k, w);
      bus.in_valid = 1'b0;
      drain();
      while (rd < n_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL unexpected_output got=%h required=none", act_res[rd[7:0]]);
        end else begin
          e = exp_q.pop_front();
          if (act_res[rd[7:0]] !== e.r) begin
            errors++; $display("FAIL vres vec=%0d got=%h required=%h", e.id, act_res[rd[7:0]], e.r);
          end
          checks++;
          if (act_t[rd[7:0]] - e.t != 4) begin
            errors++; $display("FAIL latency vec=%0d got=%0d required=4", e.id, act_t[rd[7:0]] - e.t);
          end
        end
        rd++;
      end
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    int unsigned w;
    int unsigned first;
    exp_t e;
    bus.out_ready = 1'b1;
    first = n_out;
    for (int unsigned k = 0; k < NV; k++) begin
      send(k, w);
      checks++;
      if (w != 0) begin errors++; $display("FAIL b2b_in_ready vec=%0d stall_cycles=%0d required=0", k, w); end
    end
    bus.in_valid = 1'b0;
    drain();
    while (rd < n_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL unexpected_output got=%h required=none", act_res[rd[7:0]]);
      end else begin
        e = exp_q.pop_front();
        if (act_res[rd[7:0]] !== e.r) begin
          errors++; $display("FAIL b2b_vres vec=%0d got=%h required=%h", e.id, act_res[rd[7:0]], e.r);
        end
        checks++;
        if (act_t[rd[7:0]] - e.t != 4) begin
          errors++; $display("FAIL b2b_latency vec=%0d got=%0d required=4", e.id, act_t[rd[7:0]] - e.t);
        end
        if (rd > first) begin
          checks++;
          if (act_t[rd[7:0]] != act_t[rd[7:0] - 8'd1] + 1) begin
            errors++; $display("FAIL b2b_gap vec=%0d got_cycle=%0d required=%0d", e.id, act_t[rd[7:0]], act_t[rd[7:0] - 8'd1] + 1);
          end
        end
      end
      rd++;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_stall();
    int unsigned w;
    exp_t e;
    bus.out_ready = 1'b0;
    for (int unsigned k = 0; k < 4; k++) send(k, w);
    bus.in_valid = 1'b1; bus.v1 = vt[4].a; bus.v2 = vt[4].b; bus.op = vt[4].o;
    for (int unsigned c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cycle=%0d got=%b required=0", c, bus.in_ready); end
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid cycle=%0d got=%b required=1", c, bus.out_valid); end
      checks++;
      if (bus.vres !== vt[0].r) begin errors++; $display("FAIL stall_vres_hold cycle=%0d got=%h required=%h", c, bus.vres, vt[0].r); end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL release_in_ready got=%b required=1", bus.in_ready);
    end else exp_q.push_back('{vt[4].r, cyc, 4});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drain();
    while (rd < n_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL stall_extra_output got=%h required=none", act_res[rd[7:0]]);
      end else begin
        e = exp_q.pop_front();
        if (act_res[rd[7:0]] !== e.r) begin
          errors++; $display("FAIL stall_vres vec=%0d got=%h required=%h", e.id, act_res[rd[7:0]], e.r);
        end
      end
      rd++;
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (n_out != rd || exp_q.size() != 0) begin
      errors++; $display("FAIL stall_count outputs=%0d required=%0d pending=%0d", n_out, rd, exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    int unsigned w;
    int unsigned n0;
    bus.out_ready = 1'b1;
    for (int unsigned k = 5; k < 8; k++) send(k, w);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    n0 = n_out;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got=%b required=0", bus.out_valid); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got=%b required=1", bus.in_ready); end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (n_out != n0) begin errors++; $display("FAIL midreset_flushed outputs=%0d required=%0d", n_out - n0, 0); end
    rd = n_out;
  endtask

  initial begin
    vt = '{
      '{32'h42F6_CCCD, 32'h40E8_0000, 1'b0, 32'h4302_A666},
      '{32'h42F6_CCCD, 32'h40E8_0000, 1'b1, 32'h42E8_4CCD},
      '{32'h3F80_0000, 32'hBF80_0000, 1'b0, 32'h0000_0000},
      '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000},
      '{32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000},
      '{32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000},
      '{32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000},
      '{32'h7F80_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000},
      '{32'hFF80_0000, 32'h3F80_0000, 1'b0, 32'hFF80_0000},
      '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000},
      '{32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000},
      '{32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000},
      '{32'h0040_0000, 32'h3F80_0000, 1'b0, 32'h3F80_0000},
      '{32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000},
      '{32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002},
      '{32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000},
      '{32'h3F80_0000, 32'h3380_0000, 1'b1, 32'h3F7F_FFFF},
      '{32'h7F7F_FFFF, 32'h7300_0000, 1'b0, 32'h7F80_0000},
      '{32'h3F80_0000, 32'h0080_0000, 1'b1, 32'h3F80_0000},
      '{32'h3F80_0000, 32'hC000_0000, 1'b0, 32'hBF80_0000},
      '{32'h4049_0FDB, 32'h4049_0FDB, 1'b1, 32'h0000_0000},
      '{32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0000_0000},
      '{32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000},
      '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000}
    };
    test_reset();
    test_vectors();
    test_back_to_back();
    test_stall();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
